// File: rtl/tcp_rx_pkg.sv
// Shared types and constants for the MII receive frame parser and its CRC helper.
package tcp_rx_pkg;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        HUNT      = 2'd1,
        BODY      = 2'd2,
        DROP      = 2'd3
    } state_e;

    localparam logic [2:0] ERR_NONE   = 3'd0;
    localparam logic [2:0] ERR_CRC    = 3'd1;
    localparam logic [2:0] ERR_SHORT  = 3'd2;
    localparam logic [2:0] ERR_LONG   = 3'd3;
    localparam logic [2:0] ERR_ALIGN  = 3'd4;
    localparam logic [2:0] ERR_RXER   = 3'd5;
    localparam logic [2:0] ERR_FILTER = 3'd6;

    // Byte offsets counted from the first destination MAC byte
    localparam logic [10:0] OFS_DMAC  = 11'd0;
    localparam logic [10:0] OFS_ETYPE = 11'd12;
    localparam logic [10:0] OFS_PROTO = 11'd23;
    localparam logic [10:0] OFS_SIP   = 11'd26;
    localparam logic [10:0] OFS_SPORT = 11'd34;
    localparam logic [10:0] OFS_DPORT = 11'd36;
    localparam logic [10:0] OFS_SEQ   = 11'd38;
    localparam logic [10:0] OFS_ACK   = 11'd42;
    localparam logic [10:0] OFS_FLAGS = 11'd47;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_TCP  = 8'd6;
    localparam logic [7:0]  PREAMBLE      = 8'h55;
    localparam logic [7:0]  SFD           = 8'hD5;

    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] i);
        case (i)
            3'd0:    return mac[47:40];
            3'd1:    return mac[39:32];
            3'd2:    return mac[31:24];
            3'd3:    return mac[23:16];
            3'd4:    return mac[15:8];
            default: return mac[7:0];
        endcase
    endfunction

endpackage

// File: rtl/crc32_byte.sv
// Combinational reflected CRC-32 step over one byte, LSB first.
module crc32_byte
    import tcp_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/tcp_rx_frame_parser.sv
// MII receive parser: nibble assembly, preamble/SFD hunt, CRC check, header filter
// and TCP field extraction with a one-cycle good/bad verdict after rx_dv falls.
//
// state     | meaning
// WAIT_IDLE | after reset, ignore traffic until the line goes idle
// HUNT      | count 0x55 preamble bytes, wait for SFD
// BODY      | frame bytes: CRC, index, field capture, filter
// DROP      | discard nibbles until rx_dv falls
module tcp_rx_frame_parser
    import tcp_rx_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC  = 48'h24be051e72e9,
    parameter logic [15:0] LOCAL_PORT = 16'd20,
    parameter int unsigned MIN_BYTES  = 64,
    parameter int unsigned MAX_BYTES  = 1518
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_dv,
    input  logic        rx_er,
    input  logic [3:0]  rxd,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [2:0]  err_code,
    output logic [31:0] src_ip,
    output logic [15:0] src_port,
    output logic [31:0] seq_num,
    output logic [31:0] ack_num,
    output logic [5:0]  tcp_flags,
    output logic        syn_ack,
    output logic [10:0] byte_cnt
);

    localparam int unsigned LONG_BYTES = MAX_BYTES + 1;
    localparam logic [10:0] MIN_CNT  = MIN_BYTES[10:0];
    localparam logic [10:0] LONG_CNT = LONG_BYTES[10:0];

    state_e      state_q, state_d;
    logic        phase_q, phase_d;
    logic [3:0]  lo_nib_q, lo_nib_d;
    logic [2:0]  pre_cnt_q, pre_cnt_d;
    logic [31:0] crc_q, crc_d, crc_next;
    logic [10:0] idx_q, idx_d, idx_inc;
    logic        filt_bad_q, filt_bad_d;
    logic        rxer_q, rxer_d, long_q, long_d, from_body_q, from_body_d;
    logic [31:0] sh_sip_q, sh_sip_d, sh_seq_q, sh_seq_d, sh_ack_q, sh_ack_d;
    logic [15:0] sh_sport_q, sh_sport_d;
    logic [5:0]  sh_flags_q, sh_flags_d;
    logic        frame_valid_q, frame_valid_d, frame_err_q, frame_err_d;
    logic [2:0]  err_code_q, err_code_d, err_sel;
    logic [31:0] src_ip_q, src_ip_d, seq_num_q, seq_num_d, ack_num_q, ack_num_d;
    logic [15:0] src_port_q, src_port_d;
    logic [5:0]  tcp_flags_q, tcp_flags_d;
    logic        syn_ack_q, syn_ack_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  byte_val;
    logic        byte_stb, byte_bad, end_frame;

    crc32_byte u_crc (.crc_in(crc_q), .data(byte_val), .crc_out(crc_next));

    assign byte_val = {rxd, lo_nib_q};
    assign byte_stb = rx_dv & phase_q;
    assign idx_inc  = idx_q + 11'd1;

    always_comb begin
        byte_bad = 1'b0;
        if (idx_q < OFS_DMAC + 11'd6) begin
            byte_bad = byte_val != mac_byte(LOCAL_MAC, idx_q[2:0]);
        end else begin
            case (idx_q)
                OFS_ETYPE:          byte_bad = byte_val != ETH_TYPE_IPV4[15:8];
                OFS_ETYPE + 11'd1:  byte_bad = byte_val != ETH_TYPE_IPV4[7:0];
                OFS_PROTO:          byte_bad = byte_val != IP_PROTO_TCP;
                OFS_DPORT:          byte_bad = byte_val != LOCAL_PORT[15:8];
                OFS_DPORT + 11'd1:  byte_bad = byte_val != LOCAL_PORT[7:0];
                default:            byte_bad = 1'b0;
            endcase
        end
    end

    always_comb begin
        if (rxer_q)                   err_sel = ERR_RXER;
        else if (phase_q)             err_sel = ERR_ALIGN;
        else if (long_q)              err_sel = ERR_LONG;
        else if (idx_q < MIN_CNT)     err_sel = ERR_SHORT;
        else if (crc_q != CRC_RESIDUE) err_sel = ERR_CRC;
        else if (filt_bad_q)          err_sel = ERR_FILTER;
        else                          err_sel = ERR_NONE;
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = rx_dv & ~phase_q;
        lo_nib_d      = (rx_dv & ~phase_q) ? rxd : lo_nib_q;
        pre_cnt_d     = pre_cnt_q;
        crc_d         = crc_q;
        idx_d         = idx_q;
        filt_bad_d    = filt_bad_q;
        rxer_d        = rxer_q;
        long_d        = long_q;
        from_body_d   = from_body_q;
        sh_sip_d      = sh_sip_q;
        sh_sport_d    = sh_sport_q;
        sh_seq_d      = sh_seq_q;
        sh_ack_d      = sh_ack_q;
        sh_flags_d    = sh_flags_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        err_code_d    = err_code_q;
        src_ip_d      = src_ip_q;
        src_port_d    = src_port_q;
        seq_num_d     = seq_num_q;
        ack_num_d     = ack_num_q;
        tcp_flags_d   = tcp_flags_q;
        syn_ack_d     = syn_ack_q;
        byte_cnt_d    = byte_cnt_q;
        end_frame     = 1'b0;

        case (state_q)
            WAIT_IDLE: if (!rx_dv) state_d = HUNT;
            HUNT: begin
                if (!rx_dv) begin
                    pre_cnt_d = 3'd0;
                end else if (byte_stb) begin
                    if (byte_val == PREAMBLE) begin
                        pre_cnt_d = (pre_cnt_q == 3'd7) ? 3'd7 : pre_cnt_q + 3'd1;
                    end else if (byte_val == SFD && pre_cnt_q != 3'd0) begin
                        state_d    = BODY;
                        crc_d      = CRC_INIT;
                        idx_d      = 11'd0;
                        filt_bad_d = 1'b0;
                        rxer_d     = 1'b0;
                        long_d     = 1'b0;
                        pre_cnt_d  = 3'd0;
                    end else begin
                        state_d     = DROP;
                        from_body_d = 1'b0;
                        pre_cnt_d   = 3'd0;
                    end
                end
            end
            BODY: begin
                if (!rx_dv) begin
                    end_frame = 1'b1;
                end else if (rx_er) begin
                    state_d     = DROP;
                    from_body_d = 1'b1;
                    rxer_d      = 1'b1;
                end else if (byte_stb) begin
                    crc_d      = crc_next;
                    idx_d      = idx_inc;
                    filt_bad_d = filt_bad_q | byte_bad;
                    if (idx_q >= OFS_SIP && idx_q < OFS_SIP + 11'd4)     sh_sip_d   = {sh_sip_q[23:0], byte_val};
                    if (idx_q >= OFS_SPORT && idx_q < OFS_SPORT + 11'd2) sh_sport_d = {sh_sport_q[7:0], byte_val};
                    if (idx_q >= OFS_SEQ && idx_q < OFS_SEQ + 11'd4)     sh_seq_d   = {sh_seq_q[23:0], byte_val};
                    if (idx_q >= OFS_ACK && idx_q < OFS_ACK + 11'd4)     sh_ack_d   = {sh_ack_q[23:0], byte_val};
                    if (idx_q == OFS_FLAGS)                              sh_flags_d = byte_val[5:0];
                    if (idx_inc == LONG_CNT) begin
                        state_d     = DROP;
                        from_body_d = 1'b1;
                        long_d      = 1'b1;
                    end
                end
            end
            DROP: begin
                if (!rx_dv) begin
                    if (from_body_q) end_frame = 1'b1;
                    else             state_d   = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase

        // Verdict is registered on the rx_dv-low cycle so it is visible the cycle after
        if (end_frame) begin
            state_d     = HUNT;
            from_body_d = 1'b0;
            byte_cnt_d  = idx_q;
            if (err_sel == ERR_NONE) begin
                frame_valid_d = 1'b1;
                src_ip_d      = sh_sip_q;
                src_port_d    = sh_sport_q;
                seq_num_d     = sh_seq_q;
                ack_num_d     = sh_ack_q;
                tcp_flags_d   = sh_flags_q;
                syn_ack_d     = sh_flags_q[4] & sh_flags_q[1];
            end else begin
                frame_err_d = 1'b1;
                err_code_d  = err_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= WAIT_IDLE;
            phase_q       <= 1'b0;
            lo_nib_q      <= 4'h0;
            pre_cnt_q     <= 3'd0;
            crc_q         <= CRC_INIT;
            idx_q         <= 11'd0;
            filt_bad_q    <= 1'b0;
            rxer_q        <= 1'b0;
            long_q        <= 1'b0;
            from_body_q   <= 1'b0;
            sh_sip_q      <= 32'h0;
            sh_sport_q    <= 16'h0;
            sh_seq_q      <= 32'h0;
            sh_ack_q      <= 32'h0;
            sh_flags_q    <= 6'h0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            src_ip_q      <= 32'h0;
            src_port_q    <= 16'h0;
            seq_num_q     <= 32'h0;
            ack_num_q     <= 32'h0;
            tcp_flags_q   <= 6'h0;
            syn_ack_q     <= 1'b0;
            byte_cnt_q    <= 11'd0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            lo_nib_q      <= lo_nib_d;
            pre_cnt_q     <= pre_cnt_d;
            crc_q         <= crc_d;
            idx_q         <= idx_d;
            filt_bad_q    <= filt_bad_d;
            rxer_q        <= rxer_d;
            long_q        <= long_d;
            from_body_q   <= from_body_d;
            sh_sip_q      <= sh_sip_d;
            sh_sport_q    <= sh_sport_d;
            sh_seq_q      <= sh_seq_d;
            sh_ack_q      <= sh_ack_d;
            sh_flags_q    <= sh_flags_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            err_code_q    <= err_code_d;
            src_ip_q      <= src_ip_d;
            src_port_q    <= src_port_d;
            seq_num_q     <= seq_num_d;
            ack_num_q     <= ack_num_d;
            tcp_flags_q   <= tcp_flags_d;
            syn_ack_q     <= syn_ack_d;
            byte_cnt_q    <= byte_cnt_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign err_code    = err_code_q;
    assign src_ip      = src_ip_q;
    assign src_port    = src_port_q;
    assign seq_num     = seq_num_q;
    assign ack_num     = ack_num_q;
    assign tcp_flags   = tcp_flags_q;
    assign syn_ack     = syn_ack_q;
    assign byte_cnt    = byte_cnt_q;

endmodule

// File: tb/tb_tcp_rx_frame_parser.sv
// Bench for tcp_rx_frame_parser: table of frames plus hand-built corner sequences,
// expected verdicts queued per frame and popped when rx_dv falls.
module tb_tcp_rx_frame_parser;

    localparam logic [47:0] LMAC  = 48'h24be051e72e9;
    localparam logic [31:0] SIP   = 32'hC0A80A05;
    localparam logic [15:0] SPORT = 16'hC350;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_dv = 1'b0;
    logic        rx_er = 1'b0;
    logic [3:0]  rxd = 4'h0;
    logic        frame_valid, frame_err, syn_ack;
    logic [2:0]  err_code;
    logic [31:0] src_ip, seq_num, ack_num;
    logic [15:0] src_port;
    logic [5:0]  tcp_flags;
    logic [10:0] byte_cnt;

    tcp_rx_frame_parser dut (
        .clk(clk), .rst_n(rst_n), .rx_dv(rx_dv), .rx_er(rx_er), .rxd(rxd),
        .frame_valid(frame_valid), .frame_err(frame_err), .err_code(err_code),
        .src_ip(src_ip), .src_port(src_port), .seq_num(seq_num), .ack_num(ack_num),
        .tcp_flags(tcp_flags), .syn_ack(syn_ack), .byte_cnt(byte_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          pulse;
        bit          valid;
        logic [2:0]  err;
        bit          chk_cnt;
        logic [10:0] cnt;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [5:0]  flags;
    } exp_t;

    typedef struct {
        int          len;
        logic [15:0] etype;
        logic [15:0] dport;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [5:0]  flags;
        bit          corrupt;
        bit          odd;
        bit          valid;
        logic [2:0]  err;
        logic [10:0] cnt;
    } vec_t;

    exp_t        sb[$];
    logic [7:0]  fb[$];
    vec_t        vt[10];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        prev_dv = 1'b0, last_dv = 1'b0;
    bit          rst_chk = 1'b0;
    logic [31:0] m_sip = 0, m_seq = 0, m_ack = 0;
    logic [15:0] m_sport = 0;
    logic [5:0]  m_flags = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    function automatic logic [7:0] hdr_byte(input int i, input logic [15:0] etype, input logic [15:0] dport,
                                            input logic [31:0] seq, input logic [31:0] ack, input logic [5:0] flags);
        logic [47:0] mac = LMAC;
        logic [31:0] sip = SIP;
        logic [15:0] sp = SPORT;
        logic [31:0] ii = i;
        if (i < 6)                return mac[8*(5-i) +: 8];
        if (i < 12)               return 8'h10 + ii[7:0];
        if (i == 12)              return etype[15:8];
        if (i == 13)              return etype[7:0];
        if (i == 14)              return 8'h45;
        if (i == 23)              return 8'h06;
        if (i >= 26 && i < 30)    return sip[8*(29-i) +: 8];
        if (i == 34)              return sp[15:8];
        if (i == 35)              return sp[7:0];
        if (i == 36)              return dport[15:8];
        if (i == 37)              return dport[7:0];
        if (i >= 38 && i < 42)    return seq[8*(41-i) +: 8];
        if (i >= 42 && i < 46)    return ack[8*(45-i) +: 8];
        if (i == 46)              return 8'h50;
        if (i == 47)              return {2'b00, flags};
        return ii[7:0] ^ 8'hA5;
    endfunction

    task automatic build(input int len, input logic [15:0] etype, input logic [15:0] dport,
                         input logic [31:0] seq, input logic [31:0] ack, input logic [5:0] flags, input bit corrupt);
        logic [31:0] c = 32'hFFFFFFFF;
        logic [31:0] fcs;
        fb.delete();
        for (int i = 0; i < len - 4; i++) begin
            fb.push_back(hdr_byte(i, etype, dport, seq, ack, flags));
            c = crc_upd(c, fb[i]);
        end
        fcs = ~c;
        fb.push_back(fcs[7:0]);
        fb.push_back(fcs[15:8]);
        fb.push_back(fcs[23:16]);
        fb.push_back(fcs[31:24]);
        if (corrupt) fb[len-1] = fb[len-1] ^ 8'h01;
    endtask

    task automatic check_outputs();
        exp_t e;
        if (prev_dv && !last_dv) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_empty: got frame end expected no frame (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                chk("frame_valid", 32'(frame_valid), 32'(e.pulse & e.valid));
                chk("frame_err", 32'(frame_err), 32'(e.pulse & ~e.valid));
                if (e.pulse && e.valid) begin
                    chk("seq_num", seq_num, e.seq);
                    chk("ack_num", ack_num, e.ack);
                    chk("src_ip", src_ip, SIP);
                    chk("src_port", 32'(src_port), 32'(SPORT));
                    chk("tcp_flags", 32'(tcp_flags), 32'(e.flags));
                    chk("syn_ack", 32'(syn_ack), 32'(e.flags[4] & e.flags[1]));
                    m_sip = SIP; m_sport = SPORT; m_seq = e.seq; m_ack = e.ack; m_flags = e.flags;
                end
                if (e.pulse && !e.valid) begin
                    chk("err_code", 32'(err_code), 32'(e.err));
                    chk("ack_num_held", ack_num, m_ack);
                    chk("seq_num_held", seq_num, m_seq);
                end
                if (e.pulse && e.chk_cnt) chk("byte_cnt", 32'(byte_cnt), 32'(e.cnt));
            end
        end else if (frame_valid || frame_err) begin
            n_checks++;
            n_fail++;
            $display("FAIL spurious_pulse: got valid=%0b err=%0b expected none (t=%0t)", frame_valid, frame_err, $time);
        end
    endtask

    task automatic check_zero();
        chk("rst_frame_valid", 32'(frame_valid), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_err_code", 32'(err_code), 0);
        chk("rst_src_ip", src_ip, 0);
        chk("rst_src_port", 32'(src_port), 0);
        chk("rst_seq_num", seq_num, 0);
        chk("rst_ack_num", ack_num, 0);
        chk("rst_tcp_flags", 32'(tcp_flags), 0);
        chk("rst_syn_ack", 32'(syn_ack), 0);
        chk("rst_byte_cnt", 32'(byte_cnt), 0);
        m_sip = 0; m_sport = 0; m_seq = 0; m_ack = 0; m_flags = 0;
    endtask

    task automatic step(input logic dv, input logic er, input logic [3:0] nib);
        @(negedge clk);
        check_outputs();
        if (rst_chk) begin
            check_zero();
            rst_n = 1'b1;
            rst_chk = 1'b0;
        end
        rx_dv = dv;
        rx_er = er;
        rxd = nib;
        prev_dv = last_dv;
        last_dv = dv;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0);
    endtask

    // Preamble of npre 0x55 bytes then sfd, then fb; er_at / rst_at index body bytes
    task automatic send(input int npre, input logic [7:0] sfd, input int er_at, input int rst_at, input bit odd);
        logic [7:0] b;
        for (int i = 0; i < npre; i++) begin
            step(1'b1, 1'b0, 4'h5);
            step(1'b1, 1'b0, 4'h5);
        end
        step(1'b1, 1'b0, sfd[3:0]);
        step(1'b1, 1'b0, sfd[7:4]);
        for (int k = 0; k < fb.size(); k++) begin
            b = fb[k];
            step(1'b1, k == er_at, b[3:0]);
            if (k == rst_at) begin
                rst_n = 1'b0;
                rst_chk = 1'b1;
            end
            step(1'b1, k == er_at, b[7:4]);
        end
        if (odd) step(1'b1, 1'b0, 4'h3);
        step(1'b0, 1'b0, 4'h0);
    endtask

    task automatic push_exp(input bit pulse, input bit valid, input logic [2:0] err, input bit chk_cnt,
                            input logic [10:0] cnt, input logic [31:0] seq, input logic [31:0] ack, input logic [5:0] flags);
        exp_t e;
        e.pulse = pulse; e.valid = valid; e.err = err; e.chk_cnt = chk_cnt;
        e.cnt = cnt; e.seq = seq; e.ack = ack; e.flags = flags;
        sb.push_back(e);
    endtask

    task automatic good_frame(input logic [31:0] seq, input logic [31:0] ack, input logic [5:0] flags);
        build(66, 16'h0800, 16'd20, seq, ack, flags, 1'b0);
        push_exp(1'b1, 1'b1, 3'd0, 1'b1, 11'd66, seq, ack, flags);
        send(7, 8'hD5, -1, -1, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{66,   16'h0800, 16'd20, 32'h00001000, 32'h00002711, 6'b010010, 1'b0, 1'b0, 1'b1, 3'd0, 11'd66};
        vt[1] = '{66,   16'h0800, 16'd20, 32'h00001000, 32'h00002799, 6'b010010, 1'b1, 1'b0, 1'b0, 3'd1, 11'd66};
        vt[2] = '{66,   16'h0800, 16'd80, 32'h00001000, 32'h00002799, 6'b010010, 1'b0, 1'b0, 1'b0, 3'd6, 11'd66};
        vt[3] = '{66,   16'h86DD, 16'd20, 32'h00001000, 32'h00002799, 6'b010010, 1'b0, 1'b0, 1'b0, 3'd6, 11'd66};
        vt[4] = '{40,   16'h0800, 16'd20, 32'h00001000, 32'h00002799, 6'b010010, 1'b0, 1'b0, 1'b0, 3'd2, 11'd40};
        vt[5] = '{66,   16'h0800, 16'd20, 32'h00001000, 32'h00002799, 6'b010010, 1'b0, 1'b1, 1'b0, 3'd4, 11'd66};
        vt[6] = '{64,   16'h0800, 16'd20, 32'hAABBCCDD, 32'h11223344, 6'b000010, 1'b0, 1'b0, 1'b1, 3'd0, 11'd64};
        vt[7] = '{63,   16'h0800, 16'd20, 32'h00000001, 32'h00000002, 6'b010000, 1'b0, 1'b0, 1'b0, 3'd2, 11'd63};
        vt[8] = '{1518, 16'h0800, 16'd20, 32'h0BADF00D, 32'hCAFEBABE, 6'b010001, 1'b0, 1'b0, 1'b1, 3'd0, 11'd1518};
        vt[9] = '{1519, 16'h0800, 16'd20, 32'h00000005, 32'h00000006, 6'b010010, 1'b0, 1'b0, 1'b0, 3'd3, 11'd1519};

        rst_chk = 1'b1;
        step(1'b0, 1'b0, 4'h0);
        idle(4);

        for (int i = 0; i < 10; i++) begin
            build(vt[i].len, vt[i].etype, vt[i].dport, vt[i].seq, vt[i].ack, vt[i].flags, vt[i].corrupt);
            push_exp(1'b1, vt[i].valid, vt[i].err, 1'b1, vt[i].cnt, vt[i].seq, vt[i].ack, vt[i].flags);
            send(7, 8'hD5, -1, -1, vt[i].odd);
            idle(3);
        end

        // rx_er mid-body, then a good frame whose preamble starts the very next cycle
        build(66, 16'h0800, 16'd20, 32'h00005000, 32'h00006000, 6'b010000, 1'b0);
        push_exp(1'b1, 1'b0, 3'd5, 1'b0, 11'd0, 32'h0, 32'h0, 6'h0);
        send(7, 8'hD5, 20, -1, 1'b0);
        good_frame(32'h00007000, 32'h00008000, 6'b010010);
        idle(3);

        // bad preamble byte, then SFD without preamble: both silent
        build(66, 16'h0800, 16'd20, 32'h1, 32'h2, 6'b010010, 1'b0);
        push_exp(1'b0, 1'b0, 3'd0, 1'b0, 11'd0, 32'h0, 32'h0, 6'h0);
        send(3, 8'hAA, -1, -1, 1'b0);
        idle(2);
        good_frame(32'h00009000, 32'h0000A000, 6'b011000);
        idle(2);
        build(66, 16'h0800, 16'd20, 32'h3, 32'h4, 6'b010010, 1'b0);
        push_exp(1'b0, 1'b0, 3'd0, 1'b0, 11'd0, 32'h0, 32'h0, 6'h0);
        send(0, 8'hD5, -1, -1, 1'b0);
        idle(2);
        good_frame(32'h0000B000, 32'h0000C000, 6'b010010);
        idle(2);

        // one-cycle reset at body byte 30: outputs clear, rest of frame ignored
        build(66, 16'h0800, 16'd20, 32'h5, 32'h6, 6'b010010, 1'b0);
        push_exp(1'b0, 1'b0, 3'd0, 1'b0, 11'd0, 32'h0, 32'h0, 6'h0);
        send(7, 8'hD5, -1, 30, 1'b0);
        good_frame(32'h0000D000, 32'h0000E000, 6'b010010);
        idle(5);

        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tcp_rx_frame_parser.md
Name: tcp_rx_frame_parser

Overview:
MII receive-side frame parser feeding the TCP handshake logic. It takes the raw PHY nibble stream (rxd, rx_dv, rx_er) and assembles nibbles into bytes, low nibble first. It strips the preamble and SFD, checks the Ethernet CRC-32 and filters on destination MAC, ethertype, IP protocol and TCP destination port. On a good frame it emits a one-cycle frame_valid pulse with the TCP sequence/ack numbers and flags, which drive the transmitter's sr/ack_reg inputs.

Parameters:
LOCAL_MAC, 48'h24be051e72e9, destination MAC accepted
LOCAL_PORT, 16'd20, TCP destination port accepted
MIN_BYTES, 64, minimum bytes from destination MAC through FCS inclusive
MAX_BYTES, 1518, maximum bytes from destination MAC through FCS inclusive

Ports:
clk  in  1  rx clock; one nibble sampled per rising edge while rx_dv=1
rst_n  in  1  synchronous, active-low reset
rx_dv  in  1  MII receive data valid
rx_er  in  1  MII receive error
rxd  in  4  MII receive nibble
frame_valid  out  1  one-cycle pulse: good frame accepted
frame_err  out  1  one-cycle pulse: frame rejected
err_code  out  3  reason for the last rejection, held until the next rejection
src_ip  out  32  IPv4 source address of the last good frame
src_port  out  16  TCP source port of the last good frame
seq_num  out  32  TCP sequence number of the last good frame
ack_num  out  32  TCP acknowledgement number of the last good frame
tcp_flags  out  6  {URG,ACK,PSH,RST,SYN,FIN} of the last good frame
syn_ack  out  1  level: last good frame had both SYN and ACK set
byte_cnt  out  11  byte count of the last frame, destination MAC through FCS inclusive

Behaviour:
- Reset (rst_n=0 at a clk edge): state goes to WAIT_IDLE and all outputs go to 0. Partial frames are discarded, with no pulse.
- Nibble assembly: nibble phase toggles on each rx_dv=1 sample. A byte completes on the second nibble as {second, first}. The phase clears whenever rx_dv=0.
- States:
  - WAIT_IDLE: moves to HUNT on the first cycle with rx_dv=0. A reset released mid-frame therefore ignores the rest of that frame.
  - HUNT: rx_dv=0 clears the preamble count.
    - Byte 0x55 increments the preamble count, saturating at 7.
    - Byte 0xD5 with preamble count ≥1 goes to BODY, clears the CRC to 32'hFFFFFFFF and clears the byte index.
    - Any other byte goes to DROP.
  - BODY: each byte updates the CRC and increments the index, then is captured by index (index 0 = first destination MAC byte, big-endian on the wire):
    - destination MAC: 0-5
    - ethertype: 12-13, must be 16'h0800
    - protocol: 23, must be 8'd6
    - source IP: 26-29
    - source port: 34-35
    - destination port: 36-37
    - sequence number: 38-41
    - acknowledgement number: 42-45
    - flags: byte 47 bits [5:0]
  - DROP: absorbs nibbles until rx_dv=0, then returns to HUNT.
- Transitions into DROP: rx_er=1 while rx_dv=1 in BODY goes to DROP with reason RXER. The index reaching MAX_BYTES+1 goes to DROP with reason LONG.
- End of frame: let N be the first cycle rx_dv is sampled 0 in BODY, or in DROP when entered from BODY. In cycle N+1 exactly one of frame_valid or frame_err pulses and byte_cnt updates. The state returns to HUNT.
- Errors in DROP entered from HUNT (bad preamble) are silent: no pulse.
- Rejection priority (err_code): RXER=5 > ALIGN=4 (odd nibble phase at rx_dv fall) > LONG=3 > SHORT=2 (byte_cnt<MIN_BYTES) > CRC=1 (register ≠ 32'hDEBB20E3 after FCS) > FILTER=6 (MAC, ethertype, protocol or port mismatch). Code 0 = none.
- CRC: reflected CRC-32, polynomial 32'hEDB88320, LSB first, updated over all bytes including FCS. The 32'hDEBB20E3 residue means good.
- Field outputs and syn_ack update only with frame_valid. Outputs hold between frames.
- The next frame's preamble may start in cycle N+1. HUNT must accept it without loss.

Decomposition:
- Package tcp_rx_pkg:
  - state enum {WAIT_IDLE, HUNT, BODY, DROP}
  - err_code constants
  - byte-offset constants
  - ETH_TYPE_IPV4 = 16'h0800, IP_PROTO_TCP = 8'd6
  - PREAMBLE = 8'h55, SFD = 8'hD5
  - CRC_INIT = 32'hFFFFFFFF, CRC_POLY = 32'hEDB88320, CRC_RESIDUE = 32'hDEBB20E3
- Sub-module crc32_byte: combinational next-CRC from current CRC and a data byte, reused by the TX CRC generator.

Test Plan:
- Good SYN-ACK: 66-byte frame to LOCAL_MAC, port 20, seq=32'h00001000, ack=32'h00002711, flags=6'b010010, correct FCS -> frame_valid in cycle N+1, ack_num=32'h00002711, syn_ack=1, byte_cnt=66.
- Corrupted FCS: same frame with last FCS byte XOR 8'h01 -> frame_err, err_code=1, ack_num unchanged.
- rx_er asserted at body byte 20 -> frame_err, err_code=5. A good frame immediately afterwards (preamble in cycle N+1) -> frame_valid.
- Filters: destination port 80 -> err_code=6. Ethertype 16'h86DD -> err_code=6. A 40-byte frame -> err_code=2. An odd nibble count -> err_code=4.
- Bad preamble: preamble 0x55x3 then 0xAA -> no pulse, then HUNT. SFD with no preamble (first byte 0xD5) -> no pulse.
- Reset: rst_n low for 1 cycle at body byte 30 -> all outputs 0, remaining frame ignored, next full frame accepted.
